wb_poll_master: RTL and testbench

// - Wishbone classic initiator (bus master) that mirrors the button/switch register onto the LED register.
// - Periodically reads READ_ADDR, masks the data and writes it to WRITE_ADDR.
// - Sits on the same wishbone_classic bus as the button and LED responders, replacing a CPU for board bring-up.
// - Detects missing acknowledges via a timeout.

---
 rtl/wb_poll_master_pkg.sv | 22 ++
 rtl/wb_poll_master_poll_timer.sv | 30 +++
 rtl/wb_poll_master.sv | 202 ++++++++++++++++++++
 tb/tb_wb_poll_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_poll_master_pkg.sv
// Shared types and constants for the wishbone poll master.
package wb_poll_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      WAIT = 2'd3
   } wb_poll_state_t;

   localparam logic [7:0] BTN_REG_ADDR = 8'h00;
   localparam logic [7:0] LED_REG_ADDR = 8'h10;
   localparam logic [7:0] ERR_CNT_MAX  = 8'hFF;

   // The timers are loaded with (period - 1), so they only ever hold values below max(a, b).
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/wb_poll_master_poll_timer.sv
// Loadable down-counter; done is high while the count is zero.
module wb_poll_master_poll_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt_r;

   // Count register: load wins over decrement, and the count parks at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/wb_poll_master.sv
// Wishbone classic poll master: reads READ_ADDR, masks it and writes it to WRITE_ADDR each round.
// Define WB_POLL_CHANGE_ONLY_EN to skip the write when the masked value equals the last one written.
module wb_poll_master
   import wb_poll_master_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] READ_ADDR   = ADDR_W'(BTN_REG_ADDR),
   parameter logic [ADDR_W-1:0] WRITE_ADDR  = ADDR_W'(LED_REG_ADDR),
   parameter logic [DATA_W-1:0] WR_MASK     = {DATA_W{1'b1}},
   parameter int                POLL_PERIOD = 1_000_000,
   parameter int                TIMEOUT     = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   output logic [ADDR_W-1:0]   adr_o,
   output logic [DATA_W-1:0]   dat_o,
   input  logic [DATA_W-1:0]   dat_i,
   output logic                we_o,
   output logic [DATA_W/8-1:0] sel_o,
   output logic                cyc_o,
   output logic                stb_o,
   input  logic                ack_i,
   input  logic                err_i,
   output logic                busy_o,
   output logic                timeout_o,
   output logic [7:0]          err_cnt_o
);

   localparam int            TW        = timer_width(POLL_PERIOD, TIMEOUT);
   localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_PERIOD - 1);
   localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);

   wb_poll_state_t    state_r, state_nx_s;
   logic              pp_load_s, pp_dec_s, pp_done_s;
   logic              to_load_s, to_dec_s, to_done_s;
   logic              latch_rd_s, fault_s, timeout_s;
   logic [DATA_W-1:0] rd_mask_s;
   logic [ADDR_W-1:0] adr_r;
   logic [DATA_W-1:0] dat_r;
   logic              we_r, cyc_r, timeout_r;
   logic [7:0]        err_cnt_r;
`ifdef WB_POLL_CHANGE_ONLY_EN
   logic [DATA_W-1:0] last_r;
   logic              have_last_r;
`endif

   assign rd_mask_s = dat_i & WR_MASK;

   wb_poll_master_poll_timer #(.W(TW)) u_poll_tmr (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .load     (pp_load_s),
      .load_val (POLL_LOAD),
      .dec      (pp_dec_s),
      .done     (pp_done_s)
   );

   wb_poll_master_poll_timer #(.W(TW)) u_ack_tmr (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .load     (to_load_s),
      .load_val (TO_LOAD),
      .dec      (to_dec_s),
      .done     (to_done_s)
   );

   // Next-state decode; error beats ack, and ack beats an expiring timeout.
   always_comb begin
      state_nx_s = state_r;
      pp_load_s  = 1'b0;
      pp_dec_s   = 1'b0;
      to_load_s  = 1'b0;
      to_dec_s   = 1'b0;
      latch_rd_s = 1'b0;
      fault_s    = 1'b0;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable_i) begin
               state_nx_s = RD;
               to_load_s  = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RD: begin
            if (err_i) begin
               fault_s    = 1'b1;
               state_nx_s = WAIT;
               pp_load_s  = 1'b1;
            end else if (ack_i) begin
               latch_rd_s = 1'b1;
`ifdef WB_POLL_CHANGE_ONLY_EN
               if (have_last_r && (rd_mask_s == last_r)) begin
                  state_nx_s = WAIT;
                  pp_load_s  = 1'b1;
               end else begin
                  state_nx_s = WR;
                  to_load_s  = 1'b1;
               end
`else
               state_nx_s = WR;
               to_load_s  = 1'b1;
`endif
            end else if (to_done_s) begin
               timeout_s  = 1'b1;
               fault_s    = 1'b1;
               state_nx_s = WAIT;
               pp_load_s  = 1'b1;
            end else begin
               to_dec_s   = 1'b1;
            end
         end
         WR: begin
            if (err_i) begin
               fault_s    = 1'b1;
               state_nx_s = WAIT;
               pp_load_s  = 1'b1;
            end else if (ack_i) begin
               state_nx_s = WAIT;
               pp_load_s  = 1'b1;
            end else if (to_done_s) begin
               timeout_s  = 1'b1;
               fault_s    = 1'b1;
               state_nx_s = WAIT;
               pp_load_s  = 1'b1;
            end else begin
               to_dec_s   = 1'b1;
            end
         end
         WAIT: begin
            if (pp_done_s) begin
               state_nx_s = IDLE;
            end else begin
               pp_dec_s   = 1'b1;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and bus outputs are registered from the next state so they change together.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r     <= IDLE;
         adr_r       <= {ADDR_W{1'b0}};
         dat_r       <= {DATA_W{1'b0}};
         we_r        <= 1'b0;
         cyc_r       <= 1'b0;
         timeout_r   <= 1'b0;
         err_cnt_r   <= 8'd0;
`ifdef WB_POLL_CHANGE_ONLY_EN
         last_r      <= {DATA_W{1'b0}};
         have_last_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_nx_s;
         cyc_r     <= (state_nx_s == RD) || (state_nx_s == WR);
         we_r      <= (state_nx_s == WR);
         timeout_r <= timeout_s;
         case (state_nx_s)
            RD:      adr_r <= READ_ADDR;
            WR:      adr_r <= WRITE_ADDR;
            default: adr_r <= {ADDR_W{1'b0}};
         endcase
         if (state_nx_s == WR) begin
            dat_r <= latch_rd_s ? rd_mask_s : dat_r;
         end else begin
            dat_r <= {DATA_W{1'b0}};
         end
         if (fault_s && (err_cnt_r != ERR_CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end else begin
            err_cnt_r <= err_cnt_r;
         end
`ifdef WB_POLL_CHANGE_ONLY_EN
         if ((state_r == WR) && ack_i && !err_i) begin
            last_r      <= dat_r;
            have_last_r <= 1'b1;
         end else begin
            last_r      <= last_r;
            have_last_r <= have_last_r;
         end
`endif
      end
   end

   assign adr_o     = adr_r;
   assign dat_o     = dat_r;
   assign we_o      = we_r;
   assign sel_o     = {(DATA_W/8){1'b1}};
   assign cyc_o     = cyc_r;
   assign stb_o     = cyc_r;
   assign busy_o    = cyc_r;
   assign timeout_o = timeout_r;
   assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_wb_poll_master.sv
// Directed bench for wb_poll_master with a scripted wishbone responder and transfer log.
module tb_wb_poll_master;

   localparam int M_NONE = 0, M_NORMAL = 1, M_ERR = 2, M_STUB = 3;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        enable_i = 1'b0;
   logic [7:0]  adr_o;
   logic [31:0] dat_o, dat_i;
   logic        we_o, cyc_o, stb_o, busy_o, timeout_o;
   logic [3:0]  sel_o;
   logic [7:0]  err_cnt_o;
   logic        ack_i = 1'b0;
   logic        err_i = 1'b0;

   int checks = 0;
   int errors = 0;

   int          mode = M_STUB;
   int          ack_wait = 0;
   logic [31:0] rd_data = 32'h0;
   assign dat_i = rd_data;

   // transfer log built by the responder
   logic [7:0]  q_adr[$];
   logic [31:0] q_dat[$];
   bit          q_we[$];
   bit          q_stable[$];
   int          q_len[$];
   int          q_start[$];

   int          cyc_n = 0, to_count = 0, to_long = 0, to_cycle = 0;
   bit          prev_to = 1'b0, in_xfer = 1'b0, cur_we = 1'b0, cur_stable = 1'b0;
   logic [7:0]  cur_adr = 8'h0;
   logic [31:0] cur_dat = 32'h0;
   int          cur_len = 0, cur_start = 0;

   wb_poll_master #(
      .ADDR_W(8), .DATA_W(32), .READ_ADDR(8'h00), .WRITE_ADDR(8'h10),
      .WR_MASK(32'h0000_00FF), .POLL_PERIOD(8), .TIMEOUT(4)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .adr_o(adr_o), .dat_o(dat_o),
      .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o),
      .ack_i(ack_i), .err_i(err_i), .busy_o(busy_o), .timeout_o(timeout_o),
      .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   // responder + monitor, evaluated mid-cycle
   always @(negedge clk) begin
      cyc_n = cyc_n + 1;
      if (timeout_o) begin
         to_count = to_count + 1;
         to_cycle = cyc_n;
         if (prev_to) to_long = to_long + 1;
      end
      prev_to = timeout_o;
      if (in_xfer && (!stb_o || we_o != cur_we)) begin
         q_adr.push_back(cur_adr); q_dat.push_back(cur_dat); q_we.push_back(cur_we);
         q_stable.push_back(cur_stable); q_len.push_back(cur_len); q_start.push_back(cur_start);
         in_xfer = 1'b0;
      end
      if (stb_o) begin
         if (!in_xfer) begin
            in_xfer = 1'b1; cur_we = we_o; cur_adr = adr_o; cur_dat = dat_o;
            cur_len = 1; cur_stable = 1'b1; cur_start = cyc_n;
         end else begin
            cur_len = cur_len + 1;
            if (adr_o !== cur_adr || dat_o !== cur_dat) cur_stable = 1'b0;
         end
      end
      ack_i = 1'b0;
      err_i = 1'b0;
      case (mode)
         M_NORMAL: if (stb_o && cur_len == ack_wait + 1) ack_i = 1'b1;
         M_ERR:    if (stb_o && cur_len == 1) begin ack_i = 1'b1; err_i = 1'b1; end
         M_STUB:   ack_i = 1'b1;
         default:  ack_i = 1'b0;
      endcase
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_log(input int n, input int budget);
      int i = 0;
      while (q_adr.size() < n && i < budget) begin
         @(negedge clk); #1; i++;
      end
      checks++;
      if (q_adr.size() < n) begin
         errors++;
         $display("FAIL wait_log: %0d transfers seen, required %0d", q_adr.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0; enable_i = 1'b0; mode = M_STUB;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({cyc_o, stb_o, we_o, busy_o, timeout_o} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: cyc/stb/we/busy/to=%b required 00000", {cyc_o, stb_o, we_o, busy_o, timeout_o});
      end
      checks++;
      if (sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h required f", sel_o); end
      checks++;
      if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d required 0", err_cnt_o); end
      checks++;
      if (adr_o !== 8'h0 || dat_o !== 32'h0) begin errors++; $display("FAIL reset_bus: adr=%h dat=%h required 0", adr_o, dat_o); end
      rst_i = 1'b1;
      settle(4);
      checks++;
      if (cyc_o !== 1'b0 || err_cnt_o !== 8'd0) begin
         errors++; $display("FAIL idle_ack_ignored: cyc=%b errcnt=%0d required 0/0", cyc_o, err_cnt_o);
      end
   endtask

   task automatic test_normal_round();
      int b;
      mode = M_NORMAL; ack_wait = 0; rd_data = 32'h5A5A_00A5; b = q_adr.size();
      enable_i = 1'b1;
      wait_log(b + 2, 40);
      rd_data = 32'h0000_0011;
      wait_log(b + 3, 40);
      enable_i = 1'b0;
      settle(30);
      checks++;
      if (q_adr[b] !== 8'h00 || q_we[b] !== 1'b0 || q_len[b] != 1) begin
         errors++; $display("FAIL rd_xfer: adr=%h we=%b len=%0d required 00/0/1", q_adr[b], q_we[b], q_len[b]);
      end
      checks++;
      if (q_adr[b+1] !== 8'h10 || q_we[b+1] !== 1'b1 || q_dat[b+1] !== 32'hA5 || q_len[b+1] != 1) begin
         errors++; $display("FAIL wr_xfer: adr=%h we=%b dat=%h len=%0d required 10/1/a5/1", q_adr[b+1], q_we[b+1], q_dat[b+1], q_len[b+1]);
      end
      checks++;
      if (q_start[b+1] != q_start[b] + 1) begin
         errors++; $display("FAIL back_to_back: wr start %0d required %0d", q_start[b+1], q_start[b] + 1);
      end
      // 8 WAIT cycles plus the IDLE cycle that samples enable
      checks++;
      if (q_start[b+2] - (q_start[b+1] + 1) != 9) begin
         errors++; $display("FAIL poll_gap: %0d idle cycles required 9", q_start[b+2] - (q_start[b+1] + 1));
      end
      checks++;
      if (q_adr.size() != b + 4 || q_we[b+3] !== 1'b1 || q_dat[b+3] !== 32'h11) begin
         errors++; $display("FAIL disable_completes_round: n=%0d we=%b dat=%h required %0d/1/11", q_adr.size() - b, q_we[b+3], q_dat[b+3], 4);
      end
   endtask

   task automatic test_wait_states();
      int b, t0;
      mode = M_NORMAL; ack_wait = 3; rd_data = 32'hFFFF_FF42; b = q_adr.size(); t0 = to_count;
      enable_i = 1'b1;
      wait_log(b + 2, 60);
      enable_i = 1'b0;
      settle(25);
      ack_wait = 0;
      checks++;
      if (q_len[b] != 4 || q_we[b] !== 1'b0 || q_stable[b] !== 1'b1) begin
         errors++; $display("FAIL ws_rd: len=%0d we=%b stable=%b required 4/0/1", q_len[b], q_we[b], q_stable[b]);
      end
      checks++;
      if (q_len[b+1] != 4 || q_stable[b+1] !== 1'b1 || q_dat[b+1] !== 32'h42 || q_adr[b+1] !== 8'h10) begin
         errors++; $display("FAIL ws_wr: len=%0d stable=%b dat=%h adr=%h required 4/1/42/10", q_len[b+1], q_stable[b+1], q_dat[b+1], q_adr[b+1]);
      end
      checks++;
      if (to_count != t0 || err_cnt_o !== 8'd0) begin
         errors++; $display("FAIL ws_no_fault: timeouts=%0d errcnt=%0d required 0/0", to_count - t0, err_cnt_o);
      end
   endtask

   task automatic test_timeout();
      int b, t0;
      mode = M_NONE; rd_data = 32'h0000_0077; b = q_adr.size(); t0 = to_count;
      enable_i = 1'b1;
      wait_log(b + 1, 30);
      mode = M_NORMAL;
      wait_log(b + 2, 30);
      enable_i = 1'b0;
      settle(30);
      checks++;
      if (q_len[b] != 4 || q_we[b] !== 1'b0) begin
         errors++; $display("FAIL timeout_stb_len: len=%0d we=%b required 4/0", q_len[b], q_we[b]);
      end
      checks++;
      if (to_count - t0 != 1 || to_long != 0 || to_cycle != q_start[b] + 4) begin
         errors++; $display("FAIL timeout_pulse: pulses=%0d long=%0d at=%0d required 1/0/%0d", to_count - t0, to_long, to_cycle, q_start[b] + 4);
      end
      checks++;
      if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL timeout_errcnt: got %0d required 1", err_cnt_o); end
      checks++;
      if (q_adr[b+1] !== 8'h00 || q_we[b+1] !== 1'b0 || q_start[b+1] != q_start[b] + 13) begin
         errors++; $display("FAIL timeout_next_round: adr=%h we=%b start=%0d required 00/0/%0d", q_adr[b+1], q_we[b+1], q_start[b+1], q_start[b] + 13);
      end
   endtask

   task automatic test_error();
      int b, t0, wr_seen;
      mode = M_ERR; rd_data = 32'h0000_0055; b = q_adr.size(); t0 = to_count;
      enable_i = 1'b1;
      wait_log(b + 2, 40);
      checks++;
      if (q_len[b] != 1 || q_we[b] !== 1'b0 || q_we[b+1] !== 1'b0 || q_start[b+1] != q_start[b] + 10) begin
         errors++; $display("FAIL err_no_wr: len=%0d we=%b,%b gap=%0d required 1/0,0/10", q_len[b], q_we[b], q_we[b+1], q_start[b+1] - q_start[b]);
      end
      checks++;
      if (err_cnt_o !== 8'd3) begin errors++; $display("FAIL err_count: got %0d required 3", err_cnt_o); end
      wait_log(b + 300, 3500);
      enable_i = 1'b0;
      settle(30);
      checks++;
      if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d required 255", err_cnt_o); end
      wr_seen = 0;
      for (int i = b; i < q_adr.size(); i++) if (q_we[i]) wr_seen++;
      checks++;
      if (wr_seen != 0 || to_count != t0) begin
         errors++; $display("FAIL err_rounds: writes=%0d timeouts=%0d required 0/0", wr_seen, to_count - t0);
      end
      mode = M_NORMAL;
   endtask

   task automatic test_reset_mid();
      int i = 0;
      mode = M_NONE; enable_i = 1'b1;
      while (!stb_o && i < 30) begin @(negedge clk); #1; i++; end
      checks++;
      if (stb_o !== 1'b1) begin errors++; $display("FAIL mid_start: stb=%b required 1", stb_o); end
      rst_i = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (cyc_o !== 1'b0 || stb_o !== 1'b0 || err_cnt_o !== 8'd0) begin
         errors++; $display("FAIL mid_reset: cyc=%b stb=%b errcnt=%0d required 0/0/0", cyc_o, stb_o, err_cnt_o);
      end
      rst_i = 1'b1; enable_i = 1'b0; mode = M_NORMAL;
      settle(6);
      checks++;
      if (cyc_o !== 1'b0 || timeout_o !== 1'b0) begin
         errors++; $display("FAIL mid_after: cyc=%b timeout=%b required 0/0", cyc_o, timeout_o);
      end
   endtask

   task automatic test_repeat_data();
      int b;
      mode = M_NORMAL; ack_wait = 0; rd_data = 32'hABCD_003C; b = q_adr.size();
      enable_i = 1'b1;
`ifdef WB_POLL_CHANGE_ONLY_EN
      wait_log(b + 3, 40);
      rd_data = 32'h0000_003D;
      wait_log(b + 5, 60);
      enable_i = 1'b0;
      settle(30);
      checks++;
      if (q_we[b+1] !== 1'b1 || q_dat[b+1] !== 32'h3C) begin
         errors++; $display("FAIL chg_first_wr: we=%b dat=%h required 1/3c", q_we[b+1], q_dat[b+1]);
      end
      checks++;
      if (q_we[b+2] !== 1'b0 || q_we[b+3] !== 1'b0 || q_start[b+3] != q_start[b+2] + 10) begin
         errors++; $display("FAIL chg_skip: we=%b,%b gap=%0d required 0,0/10", q_we[b+2], q_we[b+3], q_start[b+3] - q_start[b+2]);
      end
      checks++;
      if (q_we[b+4] !== 1'b1 || q_dat[b+4] !== 32'h3D) begin
         errors++; $display("FAIL chg_new_wr: we=%b dat=%h required 1/3d", q_we[b+4], q_dat[b+4]);
      end
`else
      wait_log(b + 4, 60);
      enable_i = 1'b0;
      settle(30);
      checks++;
      if (q_we[b+1] !== 1'b1 || q_dat[b+1] !== 32'h3C) begin
         errors++; $display("FAIL rep_first_wr: we=%b dat=%h required 1/3c", q_we[b+1], q_dat[b+1]);
      end
      checks++;
      if (q_we[b+3] !== 1'b1 || q_adr[b+3] !== 8'h10 || q_dat[b+3] !== 32'h3C) begin
         errors++; $display("FAIL rep_second_wr: we=%b adr=%h dat=%h required 1/10/3c", q_we[b+3], q_adr[b+3], q_dat[b+3]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_normal_round();
      test_wait_states();
      test_timeout();
      test_error();
      test_reset_mid();
      test_repeat_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
